// File: rtl/snn_cmp_pkg.sv
// Shared definitions for the SNN winner-take-all compare tree: mode encodings,
// the tie-break rule and the width-generic compare helper.
package snn_cmp_pkg;

  typedef enum logic {
    MODE_SAMPLE = 1'b0,
    MODE_WINDOW = 1'b1
  } mode_e;

  // Equal values resolve to the left operand, i.e. the lower channel index.
  localparam bit TIE_LEFT_WINS = 1'b1;

  // Widest channel value the helper compares; narrower values are zero-extended.
  localparam int MAX_W = 64;

  function automatic logic left_wins(input logic [MAX_W-1:0] l, input logic [MAX_W-1:0] r);
    return TIE_LEFT_WINS ? (l >= r) : (l > r);
  endfunction

endpackage

// File: rtl/argmax_tree_pipe_cmp_node.sv
// Registered 2-input compare node: forwards the larger {value, bin index} pair,
// the left (lower-channel) pair winning ties.
module cmp_node
  import snn_cmp_pkg::*;
#(
  parameter int p_width = 19,
  parameter int p_lg    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_l_val,
  input  logic [p_lg-1:0]    i_l_bin,
  input  logic [p_width-1:0] i_r_val,
  input  logic [p_lg-1:0]    i_r_bin,
  output logic [p_width-1:0] o_val,
  output logic [p_lg-1:0]    o_bin
);

  logic w_left;

  assign w_left = left_wins(MAX_W'(i_l_val), MAX_W'(i_r_val));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_val <= '0;
      o_bin <= '0;
    end else begin
      o_val <= w_left ? i_l_val : i_r_val;
      o_bin <= w_left ? i_l_bin : i_r_bin;
    end
  end

endmodule

// File: rtl/argmax_tree_pipe.sv
// Pipelined N-input argmax for the SNN output layer: one registered compare level
// per tree level, then an output stage holding the windowed running winner.
module argmax_tree_pipe
  import snn_cmp_pkg::*;
#(
  parameter int p_width = 19,
  parameter int p_n     = 8,
  parameter int p_lg    = $clog2(p_n)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_last,
  input  logic                   i_mode,
  input  logic [p_n*p_width-1:0] i_data,
  output logic                   o_valid,
  output logic [p_width-1:0]     o_result,
  output logic [p_n-1:0]         o_index,
  output logic [p_lg-1:0]        o_bin,
  output logic                   o_zero,
  output logic                   o_busy
);

  // Level 0 is the unregistered input; level j holds p_n>>j live nodes.
  logic [p_width-1:0] w_val [0:p_lg][0:p_n-1];
  logic [p_lg-1:0]    w_bin [0:p_lg][0:p_n-1];

  logic [p_lg:1] r_vld;
  logic [p_lg:1] r_last;
  logic [p_lg:1] r_mode;

  logic [p_width-1:0] r_acc_val;
  logic [p_lg-1:0]    r_acc_bin;
  logic               r_acc_full;

  logic [p_width-1:0] w_sel_val;
  logic [p_lg-1:0]    w_sel_bin;
  logic               w_take;
  logic               w_sel_zero;
  logic               w_window;

  for (genvar k = 0; k < p_n; k++) begin : g_leaf
    assign w_val[0][k] = i_data[k*p_width +: p_width];
    assign w_bin[0][k] = p_lg'(k);
  end

  for (genvar j = 1; j <= p_lg; j++) begin : g_lvl
    for (genvar k = 0; k < p_n; k++) begin : g_node
      if (k < (p_n >> j)) begin : g_cmp
        cmp_node #(.p_width(p_width), .p_lg(p_lg)) u_node (
          .i_clk   (i_clk),
          .i_rst   (i_rst),
          .i_l_val (w_val[j-1][2*k]),
          .i_l_bin (w_bin[j-1][2*k]),
          .i_r_val (w_val[j-1][2*k+1]),
          .i_r_bin (w_bin[j-1][2*k+1]),
          .o_val   (w_val[j][k]),
          .o_bin   (w_bin[j][k])
        );
      end else begin : g_pad
        assign w_val[j][k] = '0;
        assign w_bin[j][k] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld  <= '0;
      r_last <= '0;
      r_mode <= '0;
    end else begin
      r_vld[1]  <= i_valid;
      r_last[1] <= i_last;
      r_mode[1] <= i_mode;
      for (int j = 2; j <= p_lg; j++) begin
        r_vld[j]  <= r_vld[j-1];
        r_last[j] <= r_last[j-1];
        r_mode[j] <= r_mode[j-1];
      end
    end
  end

  // Output stage: strict '>' keeps the earliest sample on ties across a window.
  always_comb begin
    w_window   = (r_mode[p_lg] == MODE_WINDOW);
    w_take     = !r_acc_full || (w_val[p_lg][0] > r_acc_val);
    w_sel_val  = w_val[p_lg][0];
    w_sel_bin  = w_bin[p_lg][0];
    if (w_window && !w_take) begin
      w_sel_val = r_acc_val;
      w_sel_bin = r_acc_bin;
    end
    w_sel_zero = (w_sel_val == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_index    <= '0;
      o_bin      <= '0;
      o_zero     <= 1'b0;
      r_acc_val  <= '0;
      r_acc_bin  <= '0;
      r_acc_full <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r_vld[p_lg]) begin
        if (!w_window || r_last[p_lg]) begin
          o_valid  <= 1'b1;
          o_result <= w_sel_val;
          o_zero   <= w_sel_zero;
          o_bin    <= w_sel_zero ? '0 : w_sel_bin;
          o_index  <= w_sel_zero ? '0 : (p_n'(1) << w_sel_bin);
        end
        if (w_window) begin
          if (r_last[p_lg]) begin
            r_acc_full <= 1'b0;
          end else begin
            r_acc_full <= 1'b1;
            if (w_take) begin
              r_acc_val <= w_val[p_lg][0];
              r_acc_bin <= w_bin[p_lg][0];
            end
          end
        end
      end
    end
  end

  assign o_busy = r_acc_full;

endmodule

// File: tb/tb_argmax_tree_pipe.sv
// Directed bench for argmax_tree_pipe: a vector stream with per-cycle expected
// outputs, plus hand sequences for reset values and reset during an open window.
module tb_argmax_tree_pipe;

  localparam int W   = 19;
  localparam int N   = 8;
  localparam int LG  = 3;
  localparam int LAT = LG + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid, i_last, i_mode;
  logic [N*W-1:0]   i_data;
  logic             o_valid, o_zero, o_busy;
  logic [W-1:0]     o_result;
  logic [N-1:0]     o_index;
  logic [LG-1:0]    o_bin;

  always #5 clk = ~clk;

  argmax_tree_pipe #(.p_width(W), .p_n(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .i_mode   (i_mode),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_index  (o_index),
    .o_bin    (o_bin),
    .o_zero   (o_zero),
    .o_busy   (o_busy)
  );

  typedef struct {
    logic           vin;
    logic           mode;
    logic           last;
    logic [N*W-1:0] data;
    logic           ev;
    logic [W-1:0]   er;
    logic [LG-1:0]  eb;
    logic           ebusy;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk8(input int c0, input int c1, input int c2, input int c3,
                                         input int c4, input int c5, input int c6, input int c7);
    return {W'(c7), W'(c6), W'(c5), W'(c4), W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic logic [N*W-1:0] one(input int ch, input int val);
    logic [N*W-1:0] d = '0;
    d[ch*W +: W] = W'(val);
    return d;
  endfunction

  task automatic add(input logic vin, input logic mode, input logic last, input logic [N*W-1:0] data,
                     input logic ev, input int er, input int eb, input logic ebusy);
    vec_t v;
    v.vin = vin; v.mode = mode; v.last = last; v.data = data;
    v.ev = ev; v.er = W'(er); v.eb = LG'(eb); v.ebusy = ebusy;
    vq.push_back(v);
  endtask

  task automatic drive(input logic vin, input logic mode, input logic last, input logic [N*W-1:0] data);
    i_valid = vin; i_mode = mode; i_last = last; i_data = data;
  endtask

  initial begin
    int lat;
    logic [N-1:0] eidx;

    drive(0, 0, 0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  o_valid,  0);
    chk("rst_result", o_result, 0);
    chk("rst_index",  o_index,  0);
    chk("rst_bin",    o_bin,    0);
    chk("rst_zero",   o_zero,   0);
    chk("rst_busy",   o_busy,   0);
    rst = 1'b0;

    // Per-sample results
    add(1, 0, 0, pk8(5, 9, 3, 9, 0, 1, 2, 7), 1, 9, 1, 0);
    add(1, 0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) add(1, 0, 0, one(i, 100), 1, 100, i, 0);
    for (int i = 0; i < N; i++) begin
      add(1, 0, 0, one(i, 100), 1, 100, i, 0);
      add(0, 0, 0, '0, 0, 0, 0, 0);
    end
    add(1, 0, 0, pk8(7, 7, 7, 7, 7, 7, 7, 7), 1, 7, 0, 0);
    add(1, 0, 0, pk8(1, 2, 3, 4, 5, 300, 300, 6), 1, 300, 5, 0);
    add(1, 0, 0, pk8(1, 2, 3, 4, 5, 6, 8, 524287), 1, 524287, 7, 0);
    // Window of three with a cross-sample tie
    add(1, 1, 0, one(2, 50), 0, 0, 0, 1);
    add(1, 1, 0, one(6, 80), 0, 0, 0, 1);
    add(1, 1, 1, one(1, 80), 1, 80, 6, 0);
    // Mode-0 sample inside an open window
    add(1, 1, 0, one(5, 30), 0, 0, 0, 1);
    add(1, 0, 0, one(3, 200), 1, 200, 3, 1);
    add(1, 1, 1, one(0, 20), 1, 30, 5, 0);
    // i_last on a mode-0 sample must not close the window
    add(1, 1, 0, one(2, 15), 0, 0, 0, 1);
    add(1, 0, 1, one(6, 25), 1, 25, 6, 1);
    add(0, 0, 0, '0, 0, 0, 0, 1);
    add(1, 1, 1, one(1, 5), 1, 15, 2, 0);
    // Contiguous windows, one-sample window, strict replace
    add(1, 1, 1, one(7, 40), 1, 40, 7, 0);
    add(1, 1, 0, one(0, 60), 0, 0, 0, 1);
    add(1, 1, 1, one(4, 60), 1, 60, 0, 0);
    add(1, 1, 0, one(3, 70), 0, 0, 0, 1);
    add(1, 1, 1, one(5, 90), 1, 90, 5, 0);
    add(1, 1, 1, '0, 1, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int t = 0; t < vq.size() + LAT; t++) begin
      if (t < vq.size()) drive(vq[t].vin, vq[t].mode, vq[t].last, vq[t].data);
      else drive(0, 0, 0, '0);
      @(negedge clk);
      if (t >= LAT) begin
        vec_t v;
        v = vq[t-LAT];
        chk($sformatf("v%0d_valid", t-LAT), o_valid, v.ev);
        chk($sformatf("v%0d_busy", t-LAT), o_busy, v.ebusy);
        if (v.ev) begin
          eidx = (v.er == 0) ? '0 : (N'(1) << v.eb);
          chk($sformatf("v%0d_result", t-LAT), o_result, v.er);
          chk($sformatf("v%0d_bin", t-LAT), o_bin, v.eb);
          chk($sformatf("v%0d_index", t-LAT), o_index, eidx);
          chk($sformatf("v%0d_zero", t-LAT), o_zero, (v.er == 0));
        end
      end
      @(posedge clk);
      #1;
    end

    // Reset two cycles after a mode-1 sample discards it
    drive(1, 1, 0, one(2, 10));
    @(posedge clk); #1;
    drive(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("arst_valid", o_valid, 0);
    chk("arst_busy",  o_busy,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid%0d", k), o_valid, 0);
      chk($sformatf("post_rst_busy%0d", k),  o_busy,  0);
    end
    @(posedge clk); #1;
    drive(1, 1, 1, one(4, 10));
    @(posedge clk); #1;
    drive(0, 0, 0, '0);
    lat = 1;
    while (lat <= 10) begin
      @(negedge clk);
      if (o_valid) break;
      lat++;
    end
    chk("win1_latency", lat, LAT);
    chk("win1_result", o_result, 10);
    chk("win1_bin",    o_bin,    4);
    chk("win1_index",  o_index,  8'b0001_0000);
    chk("win1_zero",   o_zero,   0);
    chk("win1_busy",   o_busy,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
